// File: rtl/pio_shift_unit.sv
// ---------------------------------------------------------------------------
// pio_shift_unit
//   ISR/OSR shift engine for a PIO state machine. It handles IN/OUT shifting
//   in either direction, autopush/autopull with a single-cycle OSR refill,
//   blocking and non-blocking PUSH/PULL, and MOV loads of ISR/OSR. When the
//   current op cannot complete, it raises `stall` so the decoder holds the
//   instruction and retries it.
//
// Parameters
//   DW : data width of ISR/OSR/FIFO words (8..32)
//   CW : width of the bit-count and threshold fields
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   en                    machine/clock-divider enable (no state change when low)
//   in/out_shift_right    shift direction per register (1=right)
//   auto_push/auto_pull   autopush/autopull enables
//   push/pull_thresh      thresholds (0 means DW)
//   op_*                  instruction strobes, block flag, IN/OUT bit count
//   in_data               IN source value
//   isr/osr_load          MOV strobes
//   load_val              MOV source value
//   x_val                 X register
//   rx_full               RX FIFO status
//   rx_push, rx_data      RX FIFO write interface
//   tx_empty, tx_data     TX FIFO head
//   tx_pull               TX FIFO read interface
//   out_data              OUT bits, right-justified
//   isr, osr              shift register contents
//   isr_count, osr_count  shift register bit counts
//   stall                 hold-and-retry request
//   flag_clr              clears the sticky flags
//   rx_overflow           sticky RX overflow flag
//   tx_underflow          sticky TX underflow flag
//
// Build option
//   PIO_SHIFT_STATUS_EN : builds the sticky rx_overflow/tx_underflow flags.
//                         Without it, both flags are tied to 0.
// ---------------------------------------------------------------------------
module pio_shift_unit #(
    parameter int DW = 32,
    parameter int CW = $clog2(DW) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en,
    input  logic          in_shift_right,
    input  logic          out_shift_right,
    input  logic          auto_push,
    input  logic          auto_pull,
    input  logic [CW-1:0] push_thresh,
    input  logic [CW-1:0] pull_thresh,
    input  logic          op_in,
    input  logic          op_out,
    input  logic          op_push,
    input  logic          op_pull,
    input  logic          op_block,
    input  logic [CW-1:0] op_count,
    input  logic [DW-1:0] in_data,
    input  logic          isr_load,
    input  logic          osr_load,
    input  logic [DW-1:0] load_val,
    input  logic [DW-1:0] x_val,
    input  logic          rx_full,
    output logic          rx_push,
    output logic [DW-1:0] rx_data,
    input  logic          tx_empty,
    input  logic [DW-1:0] tx_data,
    output logic          tx_pull,
    output logic [DW-1:0] out_data,
    output logic [DW-1:0] isr,
    output logic [DW-1:0] osr,
    output logic [CW-1:0] isr_count,
    output logic [CW-1:0] osr_count,
    output logic          stall,
    input  logic          flag_clr,
    output logic          rx_overflow,
    output logic          tx_underflow
);

    localparam logic [CW-1:0] DW_C  = CW'(DW);
    localparam logic [CW:0]   DW_CX = (CW+1)'(DW);

    logic [DW-1:0] isr_reg, osr_reg;
    logic [CW-1:0] isr_count_reg, osr_count_reg;

    // Effective bit count and thresholds. A zero value means a full word.
    // Counts above DW are clamped so that shifts stay well defined.
    logic [CW-1:0] n_eff, n_rem, push_thr, pull_thr;
    logic [DW-1:0] mask;

    always_comb begin
        n_eff    = (op_count == '0 || op_count > DW_C) ? DW_C : op_count;
        n_rem    = DW_C - n_eff;
        push_thr = (push_thresh == '0) ? DW_C : push_thresh;
        pull_thr = (pull_thresh == '0) ? DW_C : pull_thresh;
        // The effective count is never 0, so the shift is at most DW-1.
        mask     = {DW{1'b1}} >> n_rem;
    end

    // Op decode. MOV loads take priority, then PUSH/PULL, then IN/OUT.
    // Within a level, PUSH wins over PULL and IN wins over OUT.
    logic do_load, do_push, do_pull, do_in, do_out;
    assign do_load = isr_load | osr_load;
    assign do_push = ~do_load & op_push;
    assign do_pull = ~do_load & ~op_push & op_pull;
    assign do_in   = ~do_load & ~op_push & ~op_pull & op_in;
    assign do_out  = ~do_load & ~op_push & ~op_pull & ~op_in & op_out;

    // IN datapath: shift, then evaluate autopush on the post-shift count.
    logic [DW-1:0] isr_shifted;
    logic [CW:0]   isr_sum;
    logic [CW-1:0] isr_cnt_sat;
    logic          autopush_hit;

    always_comb begin
        if (in_shift_right)
            isr_shifted = (isr_reg >> n_eff) | ((in_data & mask) << n_rem);
        else
            isr_shifted = (isr_reg << n_eff) | (in_data & mask);
        isr_sum      = {1'b0, isr_count_reg} + {1'b0, n_eff};
        isr_cnt_sat  = (isr_sum >= DW_CX) ? DW_C : isr_sum[CW-1:0];
        autopush_hit = auto_push && (isr_cnt_sat >= push_thr);
    end

    // OUT datapath. On refill, the TX head is shifted directly in the same
    // cycle, so the count restarts from 0.
    logic          refill_req;
    logic [DW-1:0] out_src, out_bits, osr_shifted;
    logic [CW-1:0] out_base, osr_cnt_sat;
    logic [CW:0]   osr_sum;

    always_comb begin
        refill_req  = auto_pull && (osr_count_reg >= pull_thr);
        out_src     = refill_req ? tx_data : osr_reg;
        out_base    = refill_req ? '0 : osr_count_reg;
        out_bits    = out_shift_right ? (out_src & mask) : (out_src >> n_rem);
        osr_shifted = out_shift_right ? (out_src >> n_eff) : (out_src << n_eff);
        osr_sum     = {1'b0, out_base} + {1'b0, n_eff};
        osr_cnt_sat = (osr_sum >= DW_CX) ? DW_C : osr_sum[CW-1:0];
    end

    // Stall and commit. Qualifying with reset_n drops every strobe as soon
    // as reset asserts, even between clock edges.
    logic stall_cond, commit;
    assign stall_cond = (do_push & rx_full  & op_block)
                      | (do_pull & tx_empty & op_block)
                      | (do_in   & autopush_hit & rx_full)
                      | (do_out  & refill_req & tx_empty);
    assign stall   = reset_n & en & stall_cond;
    assign commit  = reset_n & en & ~stall_cond;

    assign rx_push  = commit & ((do_push & ~rx_full) | (do_in & autopush_hit));
    assign rx_data  = rx_push ? (do_push ? isr_reg : isr_shifted) : '0;
    assign tx_pull  = commit & ((do_pull & ~tx_empty) | (do_out & refill_req));
    assign out_data = (commit & do_out) ? out_bits : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            isr_reg       <= '0;
            isr_count_reg <= '0;
            osr_reg       <= '0;
            // Start "empty" so the first autopull OUT refills.
            osr_count_reg <= DW_C;
        end else if (commit) begin
            if (isr_load) begin
                isr_reg       <= load_val;
                isr_count_reg <= '0;
            end
            if (osr_load) begin
                osr_reg       <= load_val;
                osr_count_reg <= '0;
            end
            // A non-blocking push into a full RX also clears the ISR.
            if (do_push) begin
                isr_reg       <= '0;
                isr_count_reg <= '0;
            end
            if (do_pull) begin
                osr_reg       <= tx_empty ? x_val : tx_data;
                osr_count_reg <= '0;
            end
            if (do_in) begin
                isr_reg       <= autopush_hit ? '0 : isr_shifted;
                isr_count_reg <= autopush_hit ? '0 : isr_cnt_sat;
            end
            if (do_out) begin
                osr_reg       <= osr_shifted;
                osr_count_reg <= osr_cnt_sat;
            end
        end
    end

    assign isr       = isr_reg;
    assign osr       = osr_reg;
    assign isr_count = isr_count_reg;
    assign osr_count = osr_count_reg;

`ifdef PIO_SHIFT_STATUS_EN
    logic rx_overflow_reg, tx_underflow_reg;
    logic set_ovf, set_unf;

    // Non-blocking variants never stall, so a set event is always a commit.
    assign set_ovf = commit & do_push & rx_full;
    assign set_unf = commit & do_pull & tx_empty;

    // A set event in the same cycle as a clear takes priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_overflow_reg  <= 1'b0;
            tx_underflow_reg <= 1'b0;
        end else begin
            if (set_ovf)
                rx_overflow_reg <= 1'b1;
            else if (commit & flag_clr)
                rx_overflow_reg <= 1'b0;
            if (set_unf)
                tx_underflow_reg <= 1'b1;
            else if (commit & flag_clr)
                tx_underflow_reg <= 1'b0;
        end
    end

    assign rx_overflow  = rx_overflow_reg;
    assign tx_underflow = tx_underflow_reg;
`else
    logic flag_clr_unused;
    assign flag_clr_unused = flag_clr;
    assign rx_overflow     = 1'b0;
    assign tx_underflow    = 1'b0;
`endif

endmodule

// File: tb/tb_pio_shift_unit.sv
// ---------------------------------------------------------------------------
// tb_pio_shift_unit
//   Self-checking bench for pio_shift_unit (DW=32). It runs directed
//   sequences, then randomized single-op cycles. Each cycle is predicted by a
//   word-level arithmetic model of the ISR/OSR behaviour. For shifts, the
//   model uses multiplication, division and modulo by powers of two.
// ---------------------------------------------------------------------------
module tb_pio_shift_unit;

    localparam int DW = 32;
    localparam int CW = $clog2(DW) + 1;
`ifdef PIO_SHIFT_STATUS_EN
    localparam bit STATUS = 1'b1;
`else
    localparam bit STATUS = 1'b0;
`endif

    localparam int OP_IDLE = 0, OP_IN = 1, OP_OUT = 2, OP_PUSH = 3, OP_PULL = 4,
                   OP_LDI = 5, OP_LDO = 6, OP_LD2 = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n, en, in_shift_right, out_shift_right, auto_push, auto_pull;
    logic [CW-1:0] push_thresh, pull_thresh, op_count;
    logic          op_in, op_out, op_push, op_pull, op_block, isr_load, osr_load;
    logic          rx_full, tx_empty, flag_clr;
    logic [DW-1:0] in_data, load_val, x_val, tx_data;
    logic          rx_push, tx_pull, stall, rx_overflow, tx_underflow;
    logic [DW-1:0] rx_data, out_data, isr, osr;
    logic [CW-1:0] isr_count, osr_count;

    pio_shift_unit #(.DW(DW), .CW(CW)) dut (
        .clk(clk), .reset_n(reset_n), .en(en),
        .in_shift_right(in_shift_right), .out_shift_right(out_shift_right),
        .auto_push(auto_push), .auto_pull(auto_pull),
        .push_thresh(push_thresh), .pull_thresh(pull_thresh),
        .op_in(op_in), .op_out(op_out), .op_push(op_push), .op_pull(op_pull),
        .op_block(op_block), .op_count(op_count), .in_data(in_data),
        .isr_load(isr_load), .osr_load(osr_load), .load_val(load_val), .x_val(x_val),
        .rx_full(rx_full), .rx_push(rx_push), .rx_data(rx_data),
        .tx_empty(tx_empty), .tx_data(tx_data), .tx_pull(tx_pull),
        .out_data(out_data), .isr(isr), .osr(osr),
        .isr_count(isr_count), .osr_count(osr_count), .stall(stall),
        .flag_clr(flag_clr), .rx_overflow(rx_overflow), .tx_underflow(tx_underflow)
    );

    int n_vec = 0;
    int n_err = 0;
    int op_kind;

    // Model state, next state, and expected combinational outputs.
    logic [63:0] m_isr, m_osr, n_isr, n_osr;
    int          m_isr_cnt, m_osr_cnt, n_isr_cnt, n_osr_cnt;
    bit          m_ovf, m_unf, n_ovf, n_unf;
    bit          e_stall, e_rx_push, e_tx_pull, e_out_valid;
    logic [63:0] e_rx_data, e_out_data;

    // Values observed before the last edge, for the directed checks.
    logic          obs_stall, obs_rx_push, obs_tx_pull;
    logic [DW-1:0] obs_rx_data, obs_out_data;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] p2(input int k);
        return 64'd1 << k;
    endfunction

    task automatic set_op(input int k);
        op_kind  = k;
        op_in    = (k == OP_IN);
        op_out   = (k == OP_OUT);
        op_push  = (k == OP_PUSH);
        op_pull  = (k == OP_PULL);
        isr_load = (k == OP_LDI) || (k == OP_LD2);
        osr_load = (k == OP_LDO) || (k == OP_LD2);
    endtask

    task automatic idle_inputs();
        en = 1'b1; in_shift_right = 1'b0; out_shift_right = 1'b1;
        auto_push = 1'b0; auto_pull = 1'b0; push_thresh = '0; pull_thresh = '0;
        op_block = 1'b0; op_count = '0; in_data = '0; load_val = '0; x_val = '0;
        rx_full = 1'b0; tx_empty = 1'b0; tx_data = '0; flag_clr = 1'b0;
        set_op(OP_IDLE);
    endtask

    task automatic model_reset();
        m_isr = 0; m_isr_cnt = 0; m_osr = 0; m_osr_cnt = DW; m_ovf = 0; m_unf = 0;
    endtask

    task automatic model_eval();
        int n, thr, c, base;
        logic [63:0] full, pn, v, s;
        bit refill, set_ovf, set_unf;
        full = p2(DW);
        n    = (op_count == 0) ? DW : int'(op_count);
        pn   = p2(n);
        e_stall = 0; e_rx_push = 0; e_tx_pull = 0; e_out_valid = 0;
        e_rx_data = 0; e_out_data = 0; set_ovf = 0; set_unf = 0;
        n_isr = m_isr; n_isr_cnt = m_isr_cnt; n_osr = m_osr; n_osr_cnt = m_osr_cnt;
        n_ovf = m_ovf; n_unf = m_unf;
        if (en) begin
            case (op_kind)
                OP_IN: begin
                    if (in_shift_right) v = m_isr / pn + (64'(in_data) % pn) * p2(DW - n);
                    else                v = (m_isr * pn + 64'(in_data) % pn) % full;
                    c   = (m_isr_cnt + n > DW) ? DW : m_isr_cnt + n;
                    thr = (push_thresh == 0) ? DW : int'(push_thresh);
                    if (auto_push && c >= thr) begin
                        if (rx_full) e_stall = 1;
                        else begin
                            e_rx_push = 1; e_rx_data = v; n_isr = 0; n_isr_cnt = 0;
                        end
                    end else begin
                        n_isr = v; n_isr_cnt = c;
                    end
                end
                OP_OUT: begin
                    thr    = (pull_thresh == 0) ? DW : int'(pull_thresh);
                    refill = auto_pull && (m_osr_cnt >= thr);
                    if (refill && tx_empty) e_stall = 1;
                    else begin
                        s    = refill ? 64'(tx_data) : m_osr;
                        base = refill ? 0 : m_osr_cnt;
                        e_tx_pull = refill; e_out_valid = 1;
                        if (out_shift_right) begin
                            e_out_data = s % pn; n_osr = s / pn;
                        end else begin
                            e_out_data = s / p2(DW - n); n_osr = (s * pn) % full;
                        end
                        n_osr_cnt = (base + n > DW) ? DW : base + n;
                    end
                end
                OP_PUSH: begin
                    if (!rx_full) begin
                        e_rx_push = 1; e_rx_data = m_isr; n_isr = 0; n_isr_cnt = 0;
                    end else if (op_block) e_stall = 1;
                    else begin
                        n_isr = 0; n_isr_cnt = 0; set_ovf = 1;
                    end
                end
                OP_PULL: begin
                    if (!tx_empty) begin
                        e_tx_pull = 1; n_osr = tx_data; n_osr_cnt = 0;
                    end else if (op_block) e_stall = 1;
                    else begin
                        n_osr = x_val; n_osr_cnt = 0; set_unf = 1;
                    end
                end
                OP_LDI: begin n_isr = load_val; n_isr_cnt = 0; end
                OP_LDO: begin n_osr = load_val; n_osr_cnt = 0; end
                OP_LD2: begin
                    n_isr = load_val; n_isr_cnt = 0; n_osr = load_val; n_osr_cnt = 0;
                end
                default: ;
            endcase
            if (!e_stall) begin
                n_ovf = set_ovf ? 1'b1 : (flag_clr ? 1'b0 : m_ovf);
                n_unf = set_unf ? 1'b1 : (flag_clr ? 1'b0 : m_unf);
            end
        end
        if (!STATUS) begin n_ovf = 0; n_unf = 0; end
    endtask

    // One clock: check the combinational outputs mid-cycle, then check the
    // registered state just after the edge.
    task automatic cycle();
        #1;
        model_eval();
        check_val("stall", stall, e_stall);
        check_val("rx_push", rx_push, e_rx_push);
        check_val("tx_pull", tx_pull, e_tx_pull);
        if (e_rx_push)   check_val("rx_data", rx_data, e_rx_data);
        if (e_out_valid) check_val("out_data", out_data, e_out_data);
        obs_stall = stall; obs_rx_push = rx_push; obs_tx_pull = tx_pull;
        obs_rx_data = rx_data; obs_out_data = out_data;
        @(posedge clk);
        #1;
        m_isr = n_isr; m_isr_cnt = n_isr_cnt; m_osr = n_osr; m_osr_cnt = n_osr_cnt;
        m_ovf = n_ovf; m_unf = n_unf;
        check_val("isr", isr, m_isr);
        check_val("osr", osr, m_osr);
        check_val("isr_count", isr_count, m_isr_cnt);
        check_val("osr_count", osr_count, m_osr_cnt);
        check_val("rx_overflow", rx_overflow, m_ovf);
        check_val("tx_underflow", tx_underflow, m_unf);
    endtask

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        model_reset();
        #12;
        check_val("rst_isr", isr, 0);
        check_val("rst_osr_count", osr_count, DW);
        check_val("rst_stall", stall, 0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;

        // Autopull refill and shift in the same cycle.
        auto_pull = 1'b1; pull_thresh = '0; out_shift_right = 1'b1;
        tx_data = 32'hDEADBEEF; tx_empty = 1'b0; op_count = 8; set_op(OP_OUT);
        cycle();
        check_val("t1_tx_pull", obs_tx_pull, 1);
        check_val("t1_out_data", obs_out_data, 32'hEF);
        check_val("t1_osr", osr, 32'h00DEADBE);
        check_val("t1_osr_count", osr_count, 8);

        // Three left-shift INs, then PUSH.
        idle_inputs(); op_count = 4; set_op(OP_IN);
        in_data = 32'hA; cycle();
        in_data = 32'h5; cycle();
        in_data = 32'hF; cycle();
        check_val("t2_isr", isr, 32'hA5F);
        check_val("t2_isr_count", isr_count, 12);
        set_op(OP_PUSH); cycle();
        check_val("t2_rx_push", obs_rx_push, 1);
        check_val("t2_rx_data", obs_rx_data, 32'hA5F);
        check_val("t2_isr_clr", isr, 0);

        // Autopush into a full RX stalls until RX drains.
        idle_inputs(); load_val = 32'h12; set_op(OP_LDI); cycle();
        auto_push = 1'b1; push_thresh = 8; rx_full = 1'b1;
        op_count = 8; in_data = 32'h3C; set_op(OP_IN);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_val("t3_stall", obs_stall, 1);
            check_val("t3_isr_hold", isr, 32'h12);
        end
        rx_full = 1'b0; cycle();
        check_val("t3_rx_push", obs_rx_push, 1);
        check_val("t3_rx_data", obs_rx_data, 32'h123C);
        check_val("t3_isr_count", isr_count, 0);

        // Blocking PULL on empty TX, then non-blocking PULL, then clear the flag.
        idle_inputs(); tx_empty = 1'b1; op_block = 1'b1; set_op(OP_PULL); cycle();
        check_val("t4_stall", obs_stall, 1);
        op_block = 1'b0; x_val = 32'h1234; cycle();
        check_val("t4_osr", osr, 32'h1234);
        check_val("t4_tx_pull", obs_tx_pull, 0);
        check_val("t4_underflow", tx_underflow, STATUS);
        idle_inputs(); flag_clr = 1'b1; cycle();
        check_val("t4_flag_clr", tx_underflow, 0);

        // Full-word left OUT, then a second OUT from the emptied OSR.
        idle_inputs(); out_shift_right = 1'b0; load_val = 32'h80000001;
        set_op(OP_LDO); cycle();
        op_count = 0; set_op(OP_OUT); cycle();
        check_val("t5_out_data", obs_out_data, 32'h80000001);
        check_val("t5_osr", osr, 0);
        check_val("t5_osr_count", osr_count, DW);
        cycle();
        check_val("t5_out_data2", obs_out_data, 0);

        // Reset asserted while a blocking PUSH is stalled.
        idle_inputs(); load_val = 32'h77; set_op(OP_LD2); cycle();
        rx_full = 1'b1; op_block = 1'b1; set_op(OP_PUSH);
        #1;
        check_val("t6_stall_pre", stall, 1);
        reset_n = 1'b0;
        #1;
        check_val("t6_stall", stall, 0);
        check_val("t6_rx_push", rx_push, 0);
        check_val("t6_osr_count", osr_count, DW);
        check_val("t6_isr", isr, 0);
        model_reset();
        idle_inputs();
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;

        // Randomized single-op traffic.
        for (int i = 0; i < 3000; i++) begin
            en              = ($urandom_range(0, 9) != 0);
            in_shift_right  = 1'($urandom_range(0, 1));
            out_shift_right = 1'($urandom_range(0, 1));
            auto_push       = 1'($urandom_range(0, 1));
            auto_pull       = 1'($urandom_range(0, 1));
            push_thresh     = CW'($urandom_range(0, DW));
            pull_thresh     = CW'($urandom_range(0, DW));
            op_block        = 1'($urandom_range(0, 1));
            op_count        = ($urandom_range(0, 2) == 0) ? CW'($urandom_range(0, DW))
                                                          : CW'($urandom_range(1, 8));
            in_data  = $urandom; load_val = $urandom; x_val = $urandom; tx_data = $urandom;
            rx_full  = ($urandom_range(0, 3) == 0);
            tx_empty = ($urandom_range(0, 3) == 0);
            flag_clr = ($urandom_range(0, 7) == 0);
            set_op(int'($urandom_range(0, 7)));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
